xbar_resp_rob: RTL and testbench
================================

// Module: xbar_resp_rob
// PURPOSE
//  Crossbar-side receiver for the bank SRAM-controller read-response interface (sc_xbar_*).
//  Accepts out-of-order responses tagged {channel_id, rob_num}.
//  Stores them in a per-channel reorder buffer.
//  Drains each channel strictly in rob_num order onto one round-robin-arbitrated response port toward the channels.
// PARAMETERS
//  CH_NUM     4    number of requesting channels (channel_id width CH_W = 2)
//  ROB_DEPTH  8    entries per channel (rob_num width ROB_W = 3; power of two)
//  DATA_W     128  response data width
// PORTS
//  clk_i                 in   1       clock
//  rst_i                 in   1       reset, asynchronous, active-high
//  sc_xbar_valid_i       in   1       response valid from bank
//  sc_xbar_ready_o       out  1       response accepted
//  sc_xbar_channel_id_i  in   2       destination channel
//  sc_xbar_rob_num_i     in   3       reorder slot within channel
//  sc_xbar_data_i        in   128     response data
//  xbar_ch_rsp_valid_o   out  1       in-order response valid
//  xbar_ch_rsp_ready_i   in   1       downstream accepts
//  xbar_ch_rsp_ch_id_o   out  2       channel of presented response
//  xbar_ch_rsp_data_o    out  128     presented data
//  xbar_ch_rsp_rob_num_o out  3       slot of presented response (debug/check)
// BEHAVIOUR
//  Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
//  Reset: all entry-valid bits 0; head[ch] = 0; RR pointer = 0; grant lock 0.
//    xbar_ch_rsp_valid_o = 0, sc_xbar_ready_o = 1, data/ch_id/rob_num = 0.
//  Storage: ent_vld[ch][rob] plus ent_data[ch][rob].
//  Input accept: sc_xbar_ready_o = ~ent_vld[channel_id_i][rob_num_i] (combinational on inputs).
//    - Occupied slot: stall until that slot drains; no drop or overwrite.
//  Write: on valid&ready, set ent_vld and capture data at the clock edge.
//  Head-ready: channel c is eligible when ent_vld[c][head[c]] = 1.
//  Arbitration: round-robin over eligible channels, starting at RR pointer.
//    - After each output handshake, RR pointer = granted ch + 1 (mod CH_NUM).
//  Grant lock: once valid_o = 1 without ready_i, ch_id/rob_num/data/valid are held stable until the handshake.
//  Output handshake (valid_o & ready_i): clear ent_vld[g][head[g]]; head[g] <= head[g] + 1, wrapping 7 -> 0.
//  Latency: min 1 cycle from input accept to valid_o (registered storage); 1 response/cycle throughput.
//  Simultaneous write and drain of the same slot cannot occur: the drained slot is valid, so ready_o = 0 for it.
//    - The slot freed this cycle becomes writable next cycle.
//  Slots are tracked per channel; no cross-channel ordering.
//  Reset asserted mid-operation: all stored responses are discarded immediately; outputs return to reset values.
// CONFIGURATION
//  XBAR_RESP_ROB_BYPASS_EN defined:
//    - Zero-cycle bypass path. Taken when an incoming accepted response hits head[ch] of its channel,
//      no channel is currently eligible, and the grant is unlocked.
//    - The response drives valid_o/data_o in the same cycle.
//    - If ready_i is also high, the entry is not written and head advances.
//    - Otherwise the entry is written and the grant locks on it (valid held next cycle).
//  Not defined: no bypass; min latency 1 cycle; this is the default for synthesis.
// STRUCTURE
//  Shared header mcash_xbar_defs.vh:
//    - localparams CH_NUM, CH_W, ROB_DEPTH, ROB_W, DATA_W
//    - XBAR_RSP_* field widths, reused by the xbar request side and the bank.
//  Sub-module xbar_rr_arb: CH_NUM-way round-robin arbiter.
//    - req vector, lock, advance in; one-hot grant plus index out.
//  Top holds the ROB arrays, head pointers, handshake logic and the bypass mux.
// TESTING
//  1 In-order, ch0 rob 0,1,2 back to back, ready_i = 1 -> outputs rob 0,1,2 on ch0,
//    first valid 1 cycle after accept (0 cycles with BYPASS_EN).
//  2 Out-of-order, ch1 rob 2,1,0 -> no valid_o until rob0 arrives; then 0,1,2 on consecutive cycles.
//  3 ch0/ch2/ch3 heads all ready at once, RR ptr = 0, ready_i = 1 -> grants ch0, ch2, ch3 in that order.
//  4 Backpressure: ready_i = 0 for 5 cycles with valid_o high -> ch_id/rob/data unchanged.
//    A newly eligible other channel must not steal the grant.
//  5 Slot collision: ch0 rob3 held, second ch0 rob3 presented -> sc_xbar_ready_o = 0 until rob3 drains.
//    Wrap: rob 7 -> 0 sequence across two laps preserved.
//  6 rst_i pulsed asynchronously mid-stream with 6 entries held -> valid_o = 0 immediately, ready_o = 1.
//    After reset, rob0 is accepted as head.

Source files
------------

// File: rtl/xbar_resp_rob_pkg.sv
// Shared crossbar response-side parameters and types, used by the xbar request side and the bank.
// Optional zero-cycle bypass in xbar_resp_rob is enabled by defining XBAR_RESP_ROB_BYPASS_EN.
package xbar_resp_rob_pkg;

    localparam int CH_NUM    = 4;
    localparam int CH_W      = 2;
    localparam int ROB_DEPTH = 8;
    localparam int ROB_W     = 3;
    localparam int DATA_W    = 128;

    localparam int XBAR_RSP_CH_W   = CH_W;
    localparam int XBAR_RSP_ROB_W  = ROB_W;
    localparam int XBAR_RSP_DATA_W = DATA_W;

    typedef logic [XBAR_RSP_CH_W-1:0]   ch_id_t;
    typedef logic [XBAR_RSP_ROB_W-1:0]  rob_num_t;
    typedef logic [XBAR_RSP_DATA_W-1:0] rsp_data_t;

endpackage

// File: rtl/xbar_rr_arb.sv
// N-way round-robin arbiter with grant lock; the pointer moves past the winner on each advance.
module xbar_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         lock,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] rr_idx;
    logic [W-1:0] cand;
    logic [W-1:0] lock_idx_q;
    logic         locked_q;
    logic         found;

    always_comb begin
        rr_idx = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(rr_ptr) + i) % N);
            if (!found && req[cand]) begin
                rr_idx = cand;
                found  = 1'b1;
            end
        end
    end

    assign gnt_idx = locked_q ? lock_idx_q : rr_idx;

    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else if (advance) begin
            rr_ptr   <= W'((int'(gnt_idx) + 1) % N);
            locked_q <= 1'b0;
        end else if (lock) begin
            locked_q   <= 1'b1;
            lock_idx_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/xbar_resp_rob.sv
// Per-channel reorder buffer for bank read responses, drained in rob_num order through a RR arbiter.
// Define XBAR_RESP_ROB_BYPASS_EN for the zero-cycle head bypass; default build has 1-cycle min latency.
module xbar_resp_rob
    import xbar_resp_rob_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sc_xbar_valid_i,
    output logic              sc_xbar_ready_o,
    input  logic [CH_W-1:0]   sc_xbar_channel_id_i,
    input  logic [ROB_W-1:0]  sc_xbar_rob_num_i,
    input  logic [DATA_W-1:0] sc_xbar_data_i,
    output logic              xbar_ch_rsp_valid_o,
    input  logic              xbar_ch_rsp_ready_i,
    output logic [CH_W-1:0]   xbar_ch_rsp_ch_id_o,
    output logic [DATA_W-1:0] xbar_ch_rsp_data_o,
    output logic [ROB_W-1:0]  xbar_ch_rsp_rob_num_o
);

    logic [ROB_DEPTH-1:0] ent_vld [CH_NUM];
    rsp_data_t            ent_data [CH_NUM][ROB_DEPTH];
    rob_num_t             head [CH_NUM];

    logic [CH_NUM-1:0] head_rdy;
    logic [CH_NUM-1:0] arb_req;
    logic [CH_NUM-1:0] arb_gnt;
    ch_id_t            gnt_idx;
    logic              wr_fire;
    logic              byp_hit;
    logic              rsp_valid;
    logic              out_fire;
    logic              ent_wr;

    assign sc_xbar_ready_o = ~ent_vld[sc_xbar_channel_id_i][sc_xbar_rob_num_i];
    assign wr_fire         = sc_xbar_valid_i & sc_xbar_ready_o;

    always_comb begin
        head_rdy = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            head_rdy[c] = ent_vld[c][head[c]];
        end
    end

`ifdef XBAR_RESP_ROB_BYPASS_EN
    // A locked grant always points at a stored head, so an idle head set also means unlocked.
    assign byp_hit = wr_fire && (sc_xbar_rob_num_i == head[sc_xbar_channel_id_i]) && (head_rdy == '0);
    assign arb_req = head_rdy | (byp_hit ? (CH_NUM'(1) << sc_xbar_channel_id_i) : '0);
`else
    assign byp_hit = 1'b0;
    assign arb_req = head_rdy;
`endif

    assign rsp_valid = |(arb_gnt & arb_req);
    assign out_fire  = rsp_valid & xbar_ch_rsp_ready_i;
    assign ent_wr    = wr_fire & ~(byp_hit & xbar_ch_rsp_ready_i);

    xbar_rr_arb #(
        .N (CH_NUM),
        .W (CH_W)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (arb_req),
        .lock    (rsp_valid & ~xbar_ch_rsp_ready_i),
        .advance (out_fire),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx)
    );

    assign xbar_ch_rsp_valid_o   = rsp_valid;
    assign xbar_ch_rsp_ch_id_o   = rsp_valid ? gnt_idx : '0;
    assign xbar_ch_rsp_rob_num_o = rsp_valid ? head[gnt_idx] : '0;
    assign xbar_ch_rsp_data_o    = !rsp_valid ? '0 :
                                   byp_hit    ? sc_xbar_data_i :
                                                ent_data[gnt_idx][head[gnt_idx]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                ent_vld[c] <= '0;
                head[c]    <= '0;
            end
        end else begin
            if (ent_wr) begin
                ent_vld[sc_xbar_channel_id_i][sc_xbar_rob_num_i] <= 1'b1;
            end
            if (out_fire) begin
                ent_vld[gnt_idx][head[gnt_idx]] <= 1'b0;
                head[gnt_idx]                   <= head[gnt_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ent_wr) begin
            ent_data[sc_xbar_channel_id_i][sc_xbar_rob_num_i] <= sc_xbar_data_i;
        end
    end

endmodule

// File: tb/tb_xbar_resp_rob.sv
// Directed scoreboard bench for xbar_resp_rob: expected responses queued by stimulus, popped by a monitor.
module tb_xbar_resp_rob;
    import xbar_resp_rob_pkg::*;

    logic              clk_i;
    logic              rst_i;
    logic              sc_xbar_valid_i;
    logic              sc_xbar_ready_o;
    logic [CH_W-1:0]   sc_xbar_channel_id_i;
    logic [ROB_W-1:0]  sc_xbar_rob_num_i;
    logic [DATA_W-1:0] sc_xbar_data_i;
    logic              xbar_ch_rsp_valid_o;
    logic              xbar_ch_rsp_ready_i;
    logic [CH_W-1:0]   xbar_ch_rsp_ch_id_o;
    logic [DATA_W-1:0] xbar_ch_rsp_data_o;
    logic [ROB_W-1:0]  xbar_ch_rsp_rob_num_o;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    xbar_resp_rob dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .sc_xbar_valid_i       (sc_xbar_valid_i),
        .sc_xbar_ready_o       (sc_xbar_ready_o),
        .sc_xbar_channel_id_i  (sc_xbar_channel_id_i),
        .sc_xbar_rob_num_i     (sc_xbar_rob_num_i),
        .sc_xbar_data_i        (sc_xbar_data_i),
        .xbar_ch_rsp_valid_o   (xbar_ch_rsp_valid_o),
        .xbar_ch_rsp_ready_i   (xbar_ch_rsp_ready_i),
        .xbar_ch_rsp_ch_id_o   (xbar_ch_rsp_ch_id_o),
        .xbar_ch_rsp_data_o    (xbar_ch_rsp_data_o),
        .xbar_ch_rsp_rob_num_o (xbar_ch_rsp_rob_num_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [DATA_W-1:0] mk(int ch, int rob, int tag);
        return {64'hA5A5_5A5A_0F0F_F0F0, 32'(tag), 16'(ch), 16'(rob)};
    endfunction

    task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic push(int ch, int rob, int tag);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.rob  = ROB_W'(rob);
        e.data = mk(ch, rob, tag);
        sb.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && xbar_ch_rsp_valid_o && xbar_ch_rsp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual ch=%0d rob=%0d required none", xbar_ch_rsp_ch_id_o,
                         xbar_ch_rsp_rob_num_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_ch", DATA_W'(xbar_ch_rsp_ch_id_o), DATA_W'(e.ch));
                chk("rsp_rob", DATA_W'(xbar_ch_rsp_rob_num_o), DATA_W'(e.rob));
                chk("rsp_data", xbar_ch_rsp_data_o, e.data);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the response.
    task automatic send(int ch, int rob, int tag);
        logic acc;
        acc                  = 1'b0;
        sc_xbar_valid_i      = 1'b1;
        sc_xbar_channel_id_i = CH_W'(ch);
        sc_xbar_rob_num_i    = ROB_W'(rob);
        sc_xbar_data_i       = mk(ch, rob, tag);
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk_i);
            acc = sc_xbar_ready_o;
            @(posedge clk_i);
        end
        #1;
        sc_xbar_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted ch=%0d rob=%0d", ch, rob);
        end
    endtask

    task automatic drain_wait(string name);
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk_i);
        chk(name, DATA_W'(sb.size()), '0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i                = 1'b1;
        sc_xbar_valid_i      = 1'b0;
        sc_xbar_channel_id_i = '0;
        sc_xbar_rob_num_i    = '0;
        sc_xbar_data_i       = '0;
        xbar_ch_rsp_ready_i  = 1'b0;
        #23;
        chk("rst_valid", DATA_W'(xbar_ch_rsp_valid_o), '0);
        chk("rst_ready", DATA_W'(sc_xbar_ready_o), 1);
        chk("rst_data", xbar_ch_rsp_data_o, '0);
        chk("rst_ch", DATA_W'(xbar_ch_rsp_ch_id_o), '0);
        chk("rst_rob", DATA_W'(xbar_ch_rsp_rob_num_o), '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // in-order ch0 with first-response latency
        xbar_ch_rsp_ready_i = 1'b1;
        push(0, 0, 0); push(0, 1, 0); push(0, 2, 0);
        sc_xbar_valid_i      = 1'b1;
        sc_xbar_channel_id_i = 2'd0;
        sc_xbar_rob_num_i    = 3'd0;
        sc_xbar_data_i       = mk(0, 0, 0);
        @(negedge clk_i);
`ifdef XBAR_RESP_ROB_BYPASS_EN
        chk("t1_latency_valid", DATA_W'(xbar_ch_rsp_valid_o), 1);
`else
        chk("t1_latency_valid", DATA_W'(xbar_ch_rsp_valid_o), 0);
`endif
        @(posedge clk_i);
        #1;
        send(0, 1, 0);
        send(0, 2, 0);
        sc_xbar_valid_i = 1'b0;
        drain_wait("t1_drain");

        // out-of-order ch1
        send(1, 2, 0);
        send(1, 1, 0);
        @(negedge clk_i);
        chk("t2_no_valid", DATA_W'(xbar_ch_rsp_valid_o), 0);
        @(posedge clk_i);
        #1;
        push(1, 0, 0); push(1, 1, 0); push(1, 2, 0);
        send(1, 0, 0);
        drain_wait("t2_drain");

        // RR order with pointer at 0
        pulse_reset();
        xbar_ch_rsp_ready_i = 1'b0;
        send(0, 0, 1);
        send(2, 0, 1);
        send(3, 0, 1);
        push(0, 0, 1); push(2, 0, 1); push(3, 0, 1);
        xbar_ch_rsp_ready_i = 1'b1;
        drain_wait("t3_drain");

        // backpressure: ch3 locked, ch0 (higher RR priority) must not steal
        xbar_ch_rsp_ready_i = 1'b0;
        send(3, 1, 2);
        send(0, 1, 2);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            chk("t4_hold_valid", DATA_W'(xbar_ch_rsp_valid_o), 1);
            chk("t4_hold_ch", DATA_W'(xbar_ch_rsp_ch_id_o), 3);
            chk("t4_hold_rob", DATA_W'(xbar_ch_rsp_rob_num_o), 1);
            chk("t4_hold_data", xbar_ch_rsp_data_o, mk(3, 1, 2));
        end
        @(posedge clk_i);
        #1;
        push(3, 1, 2); push(0, 1, 2);
        xbar_ch_rsp_ready_i = 1'b1;
        drain_wait("t4_drain");

        // slot collision on ch0 rob3, then wrap across two laps
        push(0, 2, 3); push(0, 3, 3);
        for (int r = 4; r < 8; r++) push(0, r, 3);
        for (int r = 0; r < 4; r++) push(0, r, 4);
        send(0, 3, 3);
        sc_xbar_valid_i      = 1'b1;
        sc_xbar_channel_id_i = 2'd0;
        sc_xbar_rob_num_i    = 3'd3;
        sc_xbar_data_i       = mk(0, 3, 4);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i);
            chk("t5_collision_ready", DATA_W'(sc_xbar_ready_o), 0);
            @(posedge clk_i);
        end
        #1;
        sc_xbar_valid_i = 1'b0;
        send(0, 2, 3);
        send(0, 3, 4);
        for (int r = 4; r < 8; r++) send(0, r, 3);
        for (int r = 0; r < 3; r++) send(0, r, 4);
        drain_wait("t5_drain");

        // async reset with six ch1 entries held
        xbar_ch_rsp_ready_i = 1'b0;
        for (int r = 0; r < 6; r++) send(1, r, 5);
        @(negedge clk_i);
        chk("t6_pre_valid", DATA_W'(xbar_ch_rsp_valid_o), 1);
        #1 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", DATA_W'(xbar_ch_rsp_valid_o), 0);
        chk("t6_rst_ready", DATA_W'(sc_xbar_ready_o), 1);
        chk("t6_rst_data", xbar_ch_rsp_data_o, '0);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        xbar_ch_rsp_ready_i = 1'b1;
        push(1, 0, 6);
        send(1, 0, 6);
        drain_wait("t6_drain");
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_idle_valid", DATA_W'(xbar_ch_rsp_valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
